// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: button-driven time-setting controller for the watch.
// Debounces MODE/INC, sequences RUN -> SET_HOUR -> SET_MIN -> COMMIT,
// owns the edit registers and drives load/second-clear, run enable and blink.
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   btn_mode_i, btn_inc_i     raw asynchronous pad buttons, active-high
//   cur_hour_i, cur_min_i     live time from the timekeeping counters
//   set_hour_o, set_min_o     edit registers
//   load_o, sec_clr_o         one-cycle commit pulses
//   run_en_o                  timekeeping enable (low while editing)
//   blink_o                   blank/show for the field being edited
//   mode_o                    00 RUN, 01 SET_HOUR, 10 SET_MIN
module watch_set_ctrl #(
    parameter int unsigned TICK_DIV    = 10000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned HOLD_MS     = 500,
    parameter int unsigned REPEAT_MS   = 100,
    parameter int unsigned BLINK_MS    = 250,
    parameter int unsigned ABORT_MS    = 10000
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic [4:0] cur_hour_i,
    input  logic [5:0] cur_min_i,
    output logic [4:0] set_hour_o,
    output logic [5:0] set_min_o,
    output logic       load_o,
    output logic       sec_clr_o,
    output logic       run_en_o,
    output logic       blink_o,
    output logic [1:0] mode_o
);

    localparam int unsigned DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned HOLD_W  = $clog2(HOLD_MS + 1);
    localparam int unsigned REP_W   = $clog2(REPEAT_MS + 1);
    localparam int unsigned BLINK_W = $clog2(BLINK_MS + 1);
    localparam int unsigned ABORT_W = $clog2(ABORT_MS + 1);
    localparam int unsigned BTN_MODE = 0;
    localparam int unsigned BTN_INC  = 1;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        COMMIT   = 2'b11
    } state_e;

    state_e                     state_q, state_d;
    logic [DIV_W-1:0]           div_q, div_d;
    logic [1:0]                 sync1_q, sync2_q, lvl_q, lvl_d, rise_c;
    logic [1:0][DB_W-1:0]       db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0]          hold_q, hold_d;
    logic [REP_W-1:0]           rep_q, rep_d;
    logic [BLINK_W-1:0]         blink_cnt_q, blink_cnt_d;
    logic [ABORT_W-1:0]         abort_q, abort_d;
    logic [4:0]                 hour_q, hour_d;
    logic [5:0]                 min_q, min_d;
    logic                       load_q, load_d, run_en_q, run_en_d, blink_q, blink_d;
    logic [1:0]                 mode_q, mode_d;
    logic                       tick_c, mode_press_c, inc_strobe_c, inc_evt_c;
    logic                       abort_c, set_c, entry_c, changed_c;

    // 1 ms tick prescaler
    always_comb begin
        tick_c = (div_q == DIV_W'(TICK_DIV - 1));
        div_d  = tick_c ? '0 : div_q + DIV_W'(1);
    end

    // Debounce: level follows the synchronized input after DEBOUNCE_MS differing ticks
    always_comb begin
        lvl_d    = lvl_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (tick_c) begin
                if (sync2_q[i] != lvl_q[i]) begin
                    if (db_cnt_q[i] == DB_W'(DEBOUNCE_MS - 1)) begin
                        lvl_d[i]    = sync2_q[i];
                        db_cnt_d[i] = '0;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_d[i] = '0;
                end
            end
        end
        rise_c       = lvl_d & ~lvl_q;
        mode_press_c = rise_c[BTN_MODE];
    end

    // Auto-repeat strobe; suppressed on the release tick
    always_comb begin
        inc_strobe_c = 1'b0;
        if (tick_c && lvl_q[BTN_INC] && lvl_d[BTN_INC]) begin
            if (hold_q != HOLD_W'(HOLD_MS)) begin
                inc_strobe_c = (hold_q == HOLD_W'(HOLD_MS - 1));
            end else begin
                inc_strobe_c = (rep_q == REP_W'(REPEAT_MS - 1));
            end
        end
        inc_evt_c = rise_c[BTN_INC] | inc_strobe_c;
        abort_c   = tick_c && (abort_q == ABORT_W'(ABORT_MS - 1)) && !mode_press_c && !inc_evt_c;
    end

    // Next-state, edit registers and registered outputs
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        case (state_q)
            RUN: begin
                if (mode_press_c) begin
                    hour_d  = (cur_hour_i > 5'd23) ? 5'd0 : cur_hour_i;
                    min_d   = (cur_min_i > 6'd59) ? 6'd0 : cur_min_i;
                    state_d = SET_HOUR;
                end
            end
            SET_HOUR: begin
                if (mode_press_c)   state_d = SET_MIN;
                else if (abort_c)   state_d = RUN;
                else if (inc_evt_c) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end
            SET_MIN: begin
                if (mode_press_c)   state_d = COMMIT;
                else if (abort_c)   state_d = RUN;
                else if (inc_evt_c) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            end
            default: state_d = RUN;
        endcase

        changed_c = (state_d != state_q);
        set_c     = (state_d == SET_HOUR) || (state_d == SET_MIN);
        entry_c   = set_c && changed_c;
        load_d    = (state_d == COMMIT);
        run_en_d  = (state_d == RUN);
        case (state_d)
            RUN:      mode_d = 2'b00;
            SET_HOUR: mode_d = 2'b01;
            default:  mode_d = 2'b10;
        endcase
    end

    // Hold/repeat, blink and inactivity counters
    always_comb begin
        hold_d      = hold_q;
        rep_d       = rep_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        abort_d     = abort_q;

        if (!lvl_d[BTN_INC] || changed_c) begin
            hold_d = '0;
            rep_d  = '0;
        end else if (tick_c && lvl_q[BTN_INC]) begin
            if (hold_q != HOLD_W'(HOLD_MS))              hold_d = hold_q + HOLD_W'(1);
            else if (rep_q == REP_W'(REPEAT_MS - 1))     rep_d  = '0;
            else                                         rep_d  = rep_q + REP_W'(1);
        end

        if (!set_c) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (entry_c || inc_evt_c) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (tick_c) begin
            if (blink_cnt_q == BLINK_W'(BLINK_MS - 1)) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end

        if (!set_c || changed_c || mode_press_c || inc_evt_c) abort_d = '0;
        else if (tick_c)                                       abort_d = abort_q + ABORT_W'(1);
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= RUN;
        else          state_q <= state_d;
    end

    // Datapath and output registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            div_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            lvl_q       <= '0;
            db_cnt_q    <= '0;
            hold_q      <= '0;
            rep_q       <= '0;
            blink_cnt_q <= '0;
            abort_q     <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            load_q      <= 1'b0;
            run_en_q    <= 1'b1;
            blink_q     <= 1'b0;
            mode_q      <= 2'b00;
        end else begin
            div_q       <= div_d;
            sync1_q     <= {btn_inc_i, btn_mode_i};
            sync2_q     <= sync1_q;
            lvl_q       <= lvl_d;
            db_cnt_q    <= db_cnt_d;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
            blink_cnt_q <= blink_cnt_d;
            abort_q     <= abort_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            load_q      <= load_d;
            run_en_q    <= run_en_d;
            blink_q     <= blink_d;
            mode_q      <= mode_d;
        end
    end

    assign set_hour_o = hour_q;
    assign set_min_o  = min_q;
    assign load_o     = load_q;
    assign sec_clr_o  = load_q;
    assign run_en_o   = run_en_q;
    assign blink_o    = blink_q;
    assign mode_o     = mode_q;

endmodule
